axi_stream_strip_header: RTL and testbench

Downstream counterpart of the header-insertion stage. It accepts a byte-oriented AXI-Stream packet, removes the first N bytes of each packet (N is supplied per packet on a config handshake), and presents them on a separate header channel. It then re-aligns the remaining payload so every output beat is MSB-packed and only the last beat may be partial. It sits between the insert-header stage (or link receive path) and payload consumers.

---
 rtl/axis_strip_pkg.sv | 32 +++
 rtl/axi_stream_strip_header_reg_slice.sv | 34 +++
 rtl/axi_stream_strip_header.sv | 99 +++++++++
 tb/tb_axi_stream_strip_header.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_strip_pkg.sv
// axis_strip_pkg: shared types, FSM states and byte-lane helpers for the header strip stage
package axis_strip_pkg;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(BW) + 1;
  typedef logic [DW-1:0] data_t;
  typedef logic [BW-1:0] keep_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;
  function automatic cnt_t popcount(input keep_t k);
    cnt_t c;
    c = '0;
    for (int i = 0; i < BW; i++) c = c + cnt_t'(k[i]);
    return c;
  endfunction
  function automatic keep_t msb_mask(input cnt_t c);
    keep_t ones;
    ones = '1;
    return ~(ones >> c);
  endfunction
  function automatic data_t lane_mask(input keep_t k);
    data_t m;
    for (int i = 0; i < BW; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction
  function automatic data_t shl_bytes(input data_t d, input int c);
    return d << (8 * c);
  endfunction
  function automatic data_t shr_bytes(input data_t d, input int c);
    return d >> (8 * c);
  endfunction
endpackage

// File: rtl/axi_stream_strip_header_reg_slice.sv
// axi_stream_reg_slice: one-entry valid/ready register for data, keep and last
module axi_stream_reg_slice #(
  parameter int DW = 32,
  parameter int KW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          ready_in,
  input  logic [DW-1:0] data_in,
  input  logic [KW-1:0] keep_in,
  input  logic          last_in,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [DW-1:0] data_out,
  output logic [KW-1:0] keep_out,
  output logic          last_out
);
  assign ready_in = !valid_out || ready_out;
  always_ff @(posedge clk)
    if (rst) begin
      valid_out <= 1'b0;
      data_out <= '0;
      keep_out <= '0;
      last_out <= 1'b0;
    end else if (ready_in) begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= data_in;
        keep_out <= keep_in;
        last_out <= last_in;
      end
    end
endmodule

// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: strips N leading bytes per packet onto a header channel and re-packs the payload
module axi_stream_strip_header
  import axis_strip_pkg::*;
#(
  parameter int DATA_WD = DW,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_strip,
  output logic                    ready_strip,
  input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
  output logic                    valid_hdr,
  input  logic                    ready_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    short_pkt
);
  state_t state;
  logic [BYTE_CNT_WD-1:0] n;
  data_t res, din, pd, hd, s_data, h_data;
  cnt_t res_cnt, m, total;
  keep_t pk, hk, s_keep, h_keep;
  logic short_q, pay_rdy, hdr_rdy, rdy, acc, pv, pl, hv, s_valid, s_last, h_valid, h_last, fits;
  assign din = data_in & lane_mask(keep_in);
  assign m = popcount(keep_in);
  assign total = res_cnt + m;
  assign fits = last_in && total <= cnt_t'(BW);
  assign rdy = (state == HEAD && hdr_rdy && pay_rdy) || (state == BODY && pay_rdy);
  assign acc = !rst && valid_in && rdy;
  assign pv = state == TAIL || (acc && (state == BODY || (last_in && m > cnt_t'(n))));
  assign pd = state == TAIL ? res : state == HEAD ? shl_bytes(din, int'(n)) : res | shr_bytes(din, int'(res_cnt));
  assign pk = state == BODY && !fits ? '1 : msb_mask(state == TAIL ? res_cnt : state == HEAD ? m - cnt_t'(n) : total);
  assign pl = state != BODY || fits;
  assign hv = acc && state == HEAD;
  assign hd = shr_bytes(din, BW - int'(n));
  assign hk = keep_in >> (BW - int'(n));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      n <= '0;
      res <= '0;
      res_cnt <= '0;
      short_q <= 1'b0;
    end else begin
      short_q <= hv && last_in && m <= cnt_t'(n);
      case (state)
        IDLE: if (valid_strip) begin
          n <= strip_cnt;
          res <= '0;
          res_cnt <= '0;
          state <= strip_cnt == '0 ? BODY : HEAD;
        end
        HEAD: if (acc) begin
          res <= shl_bytes(din, int'(n));
          res_cnt <= cnt_t'(BW) - cnt_t'(n);
          state <= last_in ? IDLE : BODY;
        end
        BODY: if (acc) begin
          res <= shl_bytes(din, BW - int'(res_cnt));
          res_cnt <= last_in ? total - cnt_t'(BW) : res_cnt;
          state <= !last_in ? BODY : fits ? IDLE : TAIL;
        end
        TAIL: if (pay_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  axi_stream_reg_slice #(.DW(DATA_WD), .KW(DATA_BYTE_WD)) u_pay (
    .clk(clk), .rst(rst),
    .valid_in(pv), .ready_in(pay_rdy), .data_in(pd), .keep_in(pk), .last_in(pl),
    .valid_out(s_valid), .ready_out(ready_out), .data_out(s_data), .keep_out(s_keep), .last_out(s_last)
  );
  axi_stream_reg_slice #(.DW(DATA_WD), .KW(DATA_BYTE_WD)) u_hdr (
    .clk(clk), .rst(rst),
    .valid_in(hv), .ready_in(hdr_rdy), .data_in(hd), .keep_in(hk), .last_in(1'b1),
    .valid_out(h_valid), .ready_out(ready_hdr), .data_out(h_data), .keep_out(h_keep), .last_out(h_last)
  );
  assign ready_strip = !rst && state == IDLE;
  assign ready_in = !rst && rdy;
  assign valid_out = !rst && s_valid;
  assign data_out = rst ? '0 : s_data;
  assign keep_out = rst ? '0 : s_keep;
  assign last_out = !rst && s_last;
  assign valid_hdr = !rst && h_valid && h_last;
  assign data_hdr = rst ? '0 : h_data;
  assign keep_hdr = rst ? '0 : h_keep;
  assign short_pkt = !rst && short_q;
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb_axi_stream_strip_header: table-driven packets plus stall, tail, header-backpressure and reset sequences
module tb_axi_stream_strip_header;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, valid_in, ready_in, last_in, valid_strip, ready_strip, valid_hdr, ready_hdr;
  logic valid_out, ready_out, last_out, short_pkt;
  logic [31:0] data_in, data_hdr, data_out;
  logic [3:0] keep_in, keep_hdr, keep_out;
  logic [1:0] strip_cnt;
  axi_stream_strip_header dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_strip(valid_strip), .ready_strip(ready_strip), .strip_cnt(strip_cnt),
    .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .short_pkt(short_pkt)
  );
  typedef struct packed {
    logic [31:0] d;
    logic [3:0] k;
    logic l;
  } beat_t;
  typedef struct packed {
    int n;
    int nb;
    logic [0:2][31:0] d;
    logic [0:2][3:0] k;
    logic hv;
    logic [31:0] hd;
    logic [3:0] hk;
    int sh;
    int np;
    logic [0:2][31:0] pd;
    logic [0:2][3:0] pk;
  } vec_t;
  vec_t vecs[8];
  beat_t pay_q[$];
  logic [35:0] hdr_q[$];
  int short_cnt = 0;
  int n_vec = 0;
  int n_miss = 0;
  always @(negedge clk) begin
    if (valid_out && ready_out) pay_q.push_back(beat_t'({data_out, keep_out, last_out}));
    if (valid_hdr && ready_hdr) hdr_q.push_back({keep_hdr, data_hdr});
    if (short_pkt) short_cnt++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic send_cfg(input int n);
    int t = 0;
    valid_strip = 1'b1;
    strip_cnt = 2'(n);
    do begin
      @(negedge clk);
      t++;
    end while (!ready_strip && t < 100);
    if (!ready_strip) chk("cfg accept timeout", ready_strip, 1'b1);
    @(posedge clk);
    #1;
    valid_strip = 1'b0;
  endtask
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_in && t < 100);
    if (!ready_in) chk("beat accept timeout", ready_in, 1'b1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask
  task automatic wait_out(input int np, input int nh);
    int t = 0;
    while ((pay_q.size() < np || hdr_q.size() < nh) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) chk("output wait timeout", 64'(pay_q.size()), 64'(np));
    repeat (4) @(negedge clk);
  endtask
  task automatic run_vec(input int i);
    vec_t v;
    int sb;
    v = vecs[i];
    pay_q.delete();
    hdr_q.delete();
    sb = short_cnt;
    send_cfg(v.n);
    for (int b = 0; b < v.nb; b++) send_beat(v.d[b], v.k[b], b == v.nb - 1);
    wait_out(v.np, int'(v.hv));
    chk($sformatf("v%0d hdr count", i), 64'(hdr_q.size()), 64'(v.hv));
    if (v.hv && hdr_q.size() > 0) chk($sformatf("v%0d hdr", i), 64'(hdr_q[0]), 64'({v.hk, v.hd}));
    chk($sformatf("v%0d short pulses", i), 64'(short_cnt - sb), 64'(v.sh));
    chk($sformatf("v%0d pay count", i), 64'(pay_q.size()), 64'(v.np));
    for (int b = 0; b < v.np && b < pay_q.size(); b++) begin
      chk($sformatf("v%0d pay%0d data", i, b), 64'(pay_q[b].d), 64'(v.pd[b]));
      chk($sformatf("v%0d pay%0d keep", i, b), 64'(pay_q[b].k), 64'(v.pk[b]));
      chk($sformatf("v%0d pay%0d last", i, b), 64'(pay_q[b].l), 64'(b == v.np - 1));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    keep_in = '0;
    last_in = 1'b0;
    valid_strip = 1'b0;
    strip_cnt = '0;
    ready_hdr = 1'b1;
    ready_out = 1'b1;
    vecs[0] = '{3, 3, '{32'h01020304, 32'h05060708, 32'h090A0B0C}, '{4'hF, 4'hF, 4'hC}, 1'b1, 32'h00010203, 4'h7, 0, 2, '{32'h04050607, 32'h08090A00, 32'h0}, '{4'hF, 4'hE, 4'h0}};
    vecs[1] = '{1, 1, '{32'h11223344, 32'h0, 32'h0}, '{4'hF, 4'h0, 4'h0}, 1'b1, 32'h00000011, 4'h1, 0, 1, '{32'h22334400, 32'h0, 32'h0}, '{4'hE, 4'h0, 4'h0}};
    vecs[2] = '{1, 2, '{32'h11223344, 32'h55667788, 32'h0}, '{4'hF, 4'hF, 4'h0}, 1'b1, 32'h00000011, 4'h1, 0, 2, '{32'h22334455, 32'h66778800, 32'h0}, '{4'hF, 4'hE, 4'h0}};
    vecs[3] = '{3, 1, '{32'hAABB0000, 32'h0, 32'h0}, '{4'hC, 4'h0, 4'h0}, 1'b1, 32'h00AABB00, 4'h6, 1, 0, '{32'h0, 32'h0, 32'h0}, '{4'h0, 4'h0, 4'h0}};
    vecs[4] = '{0, 2, '{32'h01020304, 32'hA1B2C3D4, 32'h0}, '{4'hF, 4'h8, 4'h0}, 1'b0, 32'h0, 4'h0, 0, 2, '{32'h01020304, 32'hA1000000, 32'h0}, '{4'hF, 4'h8, 4'h0}};
    vecs[5] = '{2, 2, '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0}, '{4'hF, 4'hE, 4'h0}, 1'b1, 32'h0000DEAD, 4'h3, 0, 2, '{32'hBEEFCAFE, 32'hF0000000, 32'h0}, '{4'hF, 4'h8, 4'h0}};
    vecs[6] = '{2, 1, '{32'h12340000, 32'h0, 32'h0}, '{4'hC, 4'h0, 4'h0}, 1'b1, 32'h00001234, 4'h3, 1, 0, '{32'h0, 32'h0, 32'h0}, '{4'h0, 4'h0, 4'h0}};
    vecs[7] = '{3, 1, '{32'h01020304, 32'h0, 32'h0}, '{4'hF, 4'h0, 4'h0}, 1'b1, 32'h00010203, 4'h7, 0, 1, '{32'h04000000, 32'h0, 32'h0}, '{4'h8, 4'h0, 4'h0}};
    repeat (2) @(negedge clk);
    chk("rst ready_strip", ready_strip, 1'b0);
    chk("rst ready_in", ready_in, 1'b0);
    chk("rst valid_out", valid_out, 1'b0);
    chk("rst valid_hdr", valid_hdr, 1'b0);
    chk("rst short_pkt", short_pkt, 1'b0);
    chk("rst data_out", data_out, 32'h0);
    chk("rst data_hdr", data_hdr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle ready_strip", ready_strip, 1'b1);
    chk("idle ready_in", ready_in, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) run_vec(i);
    // TAIL cycle must refuse input
    pay_q.delete();
    hdr_q.delete();
    send_cfg(1);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'hF, 1'b1);
    @(negedge clk);
    chk("tail ready_in", ready_in, 1'b0);
    chk("tail ready_strip", ready_strip, 1'b0);
    wait_out(2, 1);
    chk("tail pay count", 64'(pay_q.size()), 64'd2);
    if (pay_q.size() == 2) chk("tail beat", 64'(pay_q[1]), 64'(beat_t'({32'h66778800, 4'hE, 1'b1})));
    @(posedge clk);
    #1;
    // payload backpressure for four cycles mid-packet
    pay_q.delete();
    hdr_q.delete();
    send_cfg(3);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b0);
    ready_out = 1'b0;
    valid_in = 1'b1;
    data_in = 32'h090A0B0C;
    keep_in = 4'hC;
    last_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d valid_out", c), valid_out, 1'b1);
      chk($sformatf("stall%0d data_out", c), data_out, 32'h04050607);
      chk($sformatf("stall%0d ready_in", c), ready_in, 1'b0);
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(32'h090A0B0C, 4'hC, 1'b1);
    wait_out(2, 1);
    chk("stall pay count", 64'(pay_q.size()), 64'd2);
    if (pay_q.size() == 2) begin
      chk("stall beat0", 64'(pay_q[0]), 64'(beat_t'({32'h04050607, 4'hF, 1'b0})));
      chk("stall beat1", 64'(pay_q[1]), 64'(beat_t'({32'h08090A00, 4'hE, 1'b1})));
    end
    @(posedge clk);
    #1;
    // header backpressure holds off the next packet's HEAD beat
    pay_q.delete();
    hdr_q.delete();
    ready_hdr = 1'b0;
    send_cfg(1);
    send_beat(32'h11223344, 4'hF, 1'b1);
    send_cfg(2);
    valid_in = 1'b1;
    data_in = 32'hDEADBEEF;
    keep_in = 4'hF;
    last_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hstall%0d ready_in", c), ready_in, 1'b0);
      chk($sformatf("hstall%0d valid_hdr", c), valid_hdr, 1'b1);
      chk($sformatf("hstall%0d data_hdr", c), data_hdr, 32'h00000011);
    end
    @(posedge clk);
    #1;
    ready_hdr = 1'b1;
    send_beat(32'hDEADBEEF, 4'hF, 1'b1);
    wait_out(2, 2);
    chk("hstall hdr count", 64'(hdr_q.size()), 64'd2);
    if (hdr_q.size() == 2) begin
      chk("hstall hdr0", 64'(hdr_q[0]), 64'({4'h1, 32'h00000011}));
      chk("hstall hdr1", 64'(hdr_q[1]), 64'({4'h3, 32'h0000DEAD}));
    end
    chk("hstall pay count", 64'(pay_q.size()), 64'd2);
    if (pay_q.size() == 2) chk("hstall pay1", 64'(pay_q[1]), 64'(beat_t'({32'hBEEF0000, 4'hC, 1'b1})));
    @(posedge clk);
    #1;
    // reset mid-BODY, then a fresh packet
    send_cfg(3);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst valid_out", valid_out, 1'b0);
    chk("mrst data_out", data_out, 32'h0);
    chk("mrst keep_out", keep_out, 4'h0);
    chk("mrst valid_hdr", valid_hdr, 1'b0);
    chk("mrst ready_in", ready_in, 1'b0);
    chk("mrst ready_strip", ready_strip, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post rst valid_out", valid_out, 1'b0);
    chk("post rst valid_hdr", valid_hdr, 1'b0);
    chk("post rst ready_strip", ready_strip, 1'b1);
    @(posedge clk);
    #1;
    run_vec(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
